// File: rtl/list_collect_pkg.sv
// list_collect_pkg: shared FSM state type and default element width
package list_collect_pkg;
   typedef enum logic [2:0] {IDLE, SETTLE, CHECK, REQ, DONE} state_t;
   localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/list_collect_if.sv
// list_collect_if: req/ack/eol/value lazy-list handshake; master is the consumer
interface list_collect_if import list_collect_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
);
   logic list_ready, list_req, list_ack, list_eol;
   logic [WIDTH-1:0] list_value;
   modport master (output list_ready, list_req, input list_ack, list_eol, list_value);
   modport slave (input list_ready, list_req, output list_ack, list_eol, list_value);
endinterface

// File: rtl/list_collect_buffer.sv
// list_collect_buffer: element store with a registered read port masked to the stored length
module list_collect_buffer import list_collect_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 16,
   parameter int ADDR_W = 4,
   parameter int CNT_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [CNT_W-1:0]  count,
   output logic [WIDTH-1:0]  rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clock)
      if (we) mem[waddr] <= wdata;
   // entries at or beyond count read as zero, so stale contents never leak
   always_ff @(posedge clock)
      rd_data <= reset ? '0 : (CNT_W'(rd_addr) < count ? mem[rd_addr] : '0);
endmodule

// File: rtl/list_collect.sv
// list_collect: lazy-list sink; pulls elements until eol into a buffer,
// tracking length and signed sum, with overflow and ack-timeout aborts
module list_collect import list_collect_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 16,
   parameter int TIMEOUT = 15,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int SUM_W = WIDTH + $clog2(DEPTH),
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   list_collect_if.master    lst,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data,
   output logic [CNT_W-1:0]  count,
   output logic [SUM_W-1:0]  sum,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              timeout
);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   state_t state;
   logic [TMR_W-1:0] tmr;
   logic we;
   assign we = state == REQ && lst.list_ack;
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         lst.list_ready <= 1'b0;
         lst.list_req <= 1'b0;
         count <= '0;
         sum <= '0;
         tmr <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         overflow <= 1'b0;
         timeout <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state <= SETTLE;
               lst.list_ready <= 1'b1;
               busy <= 1'b1;
               done <= 1'b0;
               count <= '0;
               sum <= '0;
               overflow <= 1'b0;
               timeout <= 1'b0;
            end
            SETTLE: state <= CHECK;
            // eol wins over a full buffer: an exactly-full list is not an overflow
            CHECK: if (lst.list_eol || count == CNT_W'(DEPTH)) begin
               state <= DONE;
               lst.list_ready <= 1'b0;
               busy <= 1'b0;
               done <= 1'b1;
               overflow <= !lst.list_eol;
            end else begin
               state <= REQ;
               lst.list_req <= 1'b1;
               tmr <= '0;
            end
            REQ: if (lst.list_ack) begin
               state <= CHECK;
               lst.list_req <= 1'b0;
               count <= count + 1'b1;
               sum <= sum + SUM_W'($signed(lst.list_value));
            end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
               state <= DONE;
               lst.list_ready <= 1'b0;
               lst.list_req <= 1'b0;
               busy <= 1'b0;
               done <= 1'b1;
               timeout <= 1'b1;
            end else begin
               tmr <= tmr + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
   list_collect_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_buf (
      .clock,
      .reset,
      .we,
      .waddr(count[ADDR_W-1:0]),
      .wdata(lst.list_value),
      .rd_addr,
      .count,
      .rd_data
   );
endmodule
